// File: rtl/alu_exec_seq_pkg.sv
// Shared definitions for the execute sequencer: opcodes, flag bit positions,
// FSM state encoding and an opcode legality helper.
package cpu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;

  // Bit positions inside the 4-bit {carry, zero, overflow, sign} flags word
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_S = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Only the three implemented alu operations retire with a writeback
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/alu_exec_seq_if.sv
// Instruction handshake plus the alu operand/result bus of the sequencer.
// slave: the sequencer side; master: upstream issuer and alu side.
interface alu_exec_seq_if #(
  parameter int DATA_W = 8,
  parameter int RSEL_W = 2,
  parameter int OP_W   = 3
);

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [RSEL_W-1:0] in_rd;
  logic [RSEL_W-1:0] in_rs1;
  logic [RSEL_W-1:0] in_rs2;
  logic              in_imm_en;
  logic [DATA_W-1:0] in_imm;

  logic [OP_W-1:0]   alu_opcode;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic              alu_zero;
  logic              alu_ovf;
  logic              alu_sign;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
    output in_ready,
    output alu_opcode, alu_a, alu_b,
    input  alu_res, alu_carry, alu_zero, alu_ovf, alu_sign
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
    input  in_ready,
    input  alu_opcode, alu_a, alu_b,
    output alu_res, alu_carry, alu_zero, alu_ovf, alu_sign
  );

endinterface

// File: rtl/alu_exec_seq_regfile.sv
// Register file: two asynchronous operand read ports, an asynchronous debug
// read port and one synchronous write port, all cleared by reset.
module alu_exec_seq_regfile #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int RSEL_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [RSEL_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [RSEL_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [RSEL_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [RSEL_W-1:0] dbg_sel_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Synchronous clear on reset, otherwise a single write per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = regs_q[raddr_a_i];
  assign rdata_b_o  = regs_q[raddr_b_i];
  assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/alu_exec_seq.sv
// Multi-cycle execute sequencer around an external combinational alu.
// One instruction every four cycles: IDLE (accept) -> READ (drive operands)
// -> EXEC (capture alu outputs) -> WB (write result and flags, pulse done).
module alu_exec_seq
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int RSEL_W   = 2,
  parameter int OP_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  alu_exec_seq_if.slave     bus,
  output logic [3:0]        flags,
  output logic              done,
  output logic              illegal_op,
  input  logic [RSEL_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state_q;
  logic              in_ready_q;

  // Instruction fields latched at accept
  logic [OP_W-1:0]   op_q;
  logic [RSEL_W-1:0] rd_q;
  logic [RSEL_W-1:0] rs1_q;
  logic [RSEL_W-1:0] rs2_q;
  logic              imm_en_q;
  logic [DATA_W-1:0] imm_q;

  // Operands held towards the alu between READ cycles
  logic [OP_W-1:0]   alu_opcode_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;

  // alu outputs captured in EXEC, committed in WB
  logic [DATA_W-1:0] res_q;
  logic [3:0]        cflags_q;

  logic [3:0]        flags_q;
  logic              done_q;
  logic              illegal_q;

  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              op_legal;
  logic              rf_we;

  assign op_legal = op_is_legal(3'(op_q));
  // Writeback happens on the WB->IDLE edge, so the next accept sees it
  assign rf_we    = (state_q == ST_WB) && op_legal;

  alu_exec_seq_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .RSEL_W   (RSEL_W)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .we_i       (rf_we),
    .waddr_i    (rd_q),
    .wdata_i    (res_q),
    .raddr_a_i  (rs1_q),
    .rdata_a_o  (rdata_a),
    .raddr_b_i  (rs2_q),
    .rdata_b_o  (rdata_b),
    .dbg_sel_i  (dbg_sel),
    .dbg_data_o (dbg_data)
  );

  // Sequencer FSM with all outputs registered; reset discards any in-flight work
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b1;
      op_q         <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      imm_en_q     <= 1'b0;
      imm_q        <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      res_q        <= '0;
      cflags_q     <= '0;
      flags_q      <= '0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            op_q       <= bus.in_op;
            rd_q       <= bus.in_rd;
            rs1_q      <= bus.in_rs1;
            rs2_q      <= bus.in_rs2;
            imm_en_q   <= bus.in_imm_en;
            imm_q      <= bus.in_imm;
            in_ready_q <= 1'b0;
            state_q    <= ST_READ;
          end
        end
        ST_READ: begin
          alu_opcode_q <= op_q;
          alu_a_q      <= rdata_a;
          alu_b_q      <= imm_en_q ? imm_q : rdata_b;
          state_q      <= ST_EXEC;
        end
        ST_EXEC: begin
          res_q            <= bus.alu_res;
          cflags_q[FLAG_C] <= bus.alu_carry;
          cflags_q[FLAG_Z] <= bus.alu_zero;
          cflags_q[FLAG_V] <= bus.alu_ovf;
          cflags_q[FLAG_S] <= bus.alu_sign;
          done_q           <= 1'b1;
          illegal_q        <= ~op_legal;
          state_q          <= ST_WB;
        end
        ST_WB: begin
          if (op_legal) begin
            flags_q <= cflags_q;
          end
          in_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: begin
          in_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign flags          = flags_q;
  assign done           = done_q;
  assign illegal_op     = illegal_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq with a behavioural 8-bit alu in the loop.
module tb_alu_exec_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] flags;
  logic       done;
  logic       illegal_op;
  logic [1:0] dbg_sel = 2'd0;
  logic [7:0] dbg_data;

  int ntests = 0;
  int nfail  = 0;

  alu_exec_seq_if #(.DATA_W(8), .RSEL_W(2), .OP_W(3)) bus ();

  alu_exec_seq #(.DATA_W(8), .NUM_REGS(4), .RSEL_W(2), .OP_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flags      (flags),
    .done       (done),
    .illegal_op (illegal_op),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural alu: ADD/AND/NOT, zero result for any other opcode
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum       = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    bus.alu_res   = 8'h00;
    bus.alu_carry = 1'b0;
    bus.alu_ovf   = 1'b0;
    case (bus.alu_opcode)
      3'b000: begin
        bus.alu_res   = alu_sum[7:0];
        bus.alu_carry = alu_sum[8];
        bus.alu_ovf   = (bus.alu_a[7] == bus.alu_b[7]) && (alu_sum[7] != bus.alu_a[7]);
      end
      3'b001:  bus.alu_res = bus.alu_a & bus.alu_b;
      3'b010:  bus.alu_res = ~bus.alu_a;
      default: bus.alu_res = 8'h00;
    endcase
    bus.alu_zero = (bus.alu_res == 8'h00);
    bus.alu_sign = bus.alu_res[7];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic rd_reg(input logic [1:0] sel, output logic [7:0] d);
    dbg_sel = sel;
    #1;
    d = dbg_data;
  endtask

  // Issue one instruction; lat = cycles from accept cycle to done (-1 on timeout)
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic ie, input logic [7:0] imm,
                       output int lat, output logic ill);
    int w;
    @(posedge clk); #1;
    bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    bus.in_imm_en = ie; bus.in_imm = imm; bus.in_valid = 1'b1;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
    lat = -1; ill = 1'b0;
    if (w >= 20) begin bus.in_valid = 1'b0; return; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    w = 0;
    while (done !== 1'b1 && w < 10) begin @(posedge clk); #1; w++; end
    if (done === 1'b1) begin lat = w + 1; ill = illegal_op; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ntests++; if (bus.in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    ntests++; if ({done, illegal_op} !== 2'b00) begin nfail++; $display("FAIL reset_pulses: got %b want 00", {done, illegal_op}); end
    ntests++; if (flags !== 4'b0000) begin nfail++; $display("FAIL reset_flags: got %b want 0000", flags); end
    ntests++; if ({bus.alu_opcode, bus.alu_a, bus.alu_b} !== 19'h0) begin nfail++; $display("FAIL reset_alu_bus: got %h want 0", {bus.alu_opcode, bus.alu_a, bus.alu_b}); end
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), d);
      ntests++; if (d !== 8'h00) begin nfail++; $display("FAIL reset_reg%0d: got %h want 00", i, d); end
    end
  endtask

  task automatic test_add_imm();
    int lat; logic ill; logic [7:0] d;
    issue(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 8'h0F, lat, ill);
    ntests++; if (lat !== 3) begin nfail++; $display("FAIL add_imm_latency: got %0d want 3", lat); end
    ntests++; if (ill !== 1'b0) begin nfail++; $display("FAIL add_imm_illegal: got %b want 0", ill); end
    rd_reg(2'd1, d);
    ntests++; if (d !== 8'h0F) begin nfail++; $display("FAIL add_imm_r1: got %h want 0f", d); end
    ntests++; if (flags !== 4'b0000) begin nfail++; $display("FAIL add_imm_flags: got %b want 0000", flags); end
  endtask

  task automatic test_add_overflow();
    int lat; logic ill; logic [7:0] d;
    issue(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F, lat, ill);
    issue(3'b000, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01, lat, ill);
    rd_reg(2'd2, d);
    ntests++; if (d !== 8'h80) begin nfail++; $display("FAIL add_ovf_r2: got %h want 80", d); end
    ntests++; if (flags !== 4'b0011) begin nfail++; $display("FAIL add_ovf_flags: got %b want 0011", flags); end
  endtask

  task automatic test_add_carry_zero();
    int lat; logic ill; logic [7:0] d;
    issue(3'b000, 2'd2, 2'd0, 2'd0, 1'b1, 8'hFF, lat, ill);
    ntests++; if (flags !== 4'b0001) begin nfail++; $display("FAIL load_ff_flags: got %b want 0001", flags); end
    issue(3'b000, 2'd3, 2'd2, 2'd0, 1'b1, 8'h01, lat, ill);
    rd_reg(2'd3, d);
    ntests++; if (d !== 8'h00) begin nfail++; $display("FAIL add_cz_r3: got %h want 00", d); end
    ntests++; if (flags !== 4'b1100) begin nfail++; $display("FAIL add_cz_flags: got %b want 1100", flags); end
  endtask

  task automatic test_and_reg();
    int lat; logic ill; logic [7:0] d;
    issue(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 8'hCC, lat, ill);
    issue(3'b000, 2'd2, 2'd0, 2'd0, 1'b1, 8'hAA, lat, ill);
    // rd == rs1: source must be the pre-write value
    issue(3'b001, 2'd1, 2'd1, 2'd2, 1'b0, 8'hFF, lat, ill);
    rd_reg(2'd1, d);
    ntests++; if (d !== 8'h88) begin nfail++; $display("FAIL and_r1: got %h want 88", d); end
    ntests++; if (flags !== 4'b0001) begin nfail++; $display("FAIL and_flags: got %b want 0001", flags); end
    ntests++; if ({bus.alu_opcode, bus.alu_a, bus.alu_b} !== {3'b001, 8'hCC, 8'hAA}) begin
      nfail++; $display("FAIL and_alu_hold: got %h want %h", {bus.alu_opcode, bus.alu_a, bus.alu_b}, {3'b001, 8'hCC, 8'hAA});
    end
  endtask

  task automatic test_not();
    int lat; logic ill; logic [7:0] d;
    issue(3'b000, 2'd3, 2'd0, 2'd0, 1'b1, 8'h0F, lat, ill);
    issue(3'b010, 2'd0, 2'd3, 2'd1, 1'b0, 8'h00, lat, ill);
    rd_reg(2'd0, d);
    ntests++; if (d !== 8'hF0) begin nfail++; $display("FAIL not_r0: got %h want f0", d); end
    ntests++; if (flags !== 4'b0001) begin nfail++; $display("FAIL not_flags: got %b want 0001", flags); end
  endtask

  task automatic test_illegal();
    int lat; logic ill; logic [7:0] d;
    issue(3'b111, 2'd1, 2'd0, 2'd0, 1'b1, 8'h00, lat, ill);
    ntests++; if (lat !== 3) begin nfail++; $display("FAIL illegal_latency: got %0d want 3", lat); end
    ntests++; if (ill !== 1'b1) begin nfail++; $display("FAIL illegal_pulse: got %b want 1", ill); end
    rd_reg(2'd1, d);
    ntests++; if (d !== 8'h88) begin nfail++; $display("FAIL illegal_r1: got %h want 88", d); end
    ntests++; if (flags !== 4'b0001) begin nfail++; $display("FAIL illegal_flags: got %b want 0001", flags); end
  endtask

  task automatic test_reset_mid_exec();
    logic [7:0] d; int seen;
    @(posedge clk); #1;
    bus.in_op = 3'b000; bus.in_rd = 2'd2; bus.in_rs1 = 2'd0; bus.in_rs2 = 2'd0;
    bus.in_imm_en = 1'b1; bus.in_imm = 8'h01; bus.in_valid = 1'b1;
    @(posedge clk); #1;  // accepted, now READ
    bus.in_valid = 1'b0;
    @(posedge clk); #1;  // now EXEC
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ntests++; if (bus.in_ready !== 1'b1) begin nfail++; $display("FAIL rst_exec_in_ready: got %b want 1", bus.in_ready); end
    ntests++; if (flags !== 4'b0000) begin nfail++; $display("FAIL rst_exec_flags: got %b want 0000", flags); end
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (done !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    ntests++; if (seen !== 0) begin nfail++; $display("FAIL rst_exec_done: got %0d pulses want 0", seen); end
    rd_reg(2'd2, d);
    ntests++; if (d !== 8'h00) begin nfail++; $display("FAIL rst_exec_r2: got %h want 00", d); end
    rd_reg(2'd0, d);
    ntests++; if (d !== 8'h00) begin nfail++; $display("FAIL rst_exec_r0: got %h want 00", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d; int nacc; int ndone; int bedge; logic will_acc;
    @(posedge clk); #1;
    bus.in_op = 3'b000; bus.in_rd = 2'd1; bus.in_rs1 = 2'd0; bus.in_rs2 = 2'd0;
    bus.in_imm_en = 1'b1; bus.in_imm = 8'h05; bus.in_valid = 1'b1;
    @(posedge clk); #1;  // A accepted
    ntests++; if (bus.in_ready !== 1'b0) begin nfail++; $display("FAIL b2b_busy_ready: got %b want 0", bus.in_ready); end
    // B = r1 + 1, held valid while the sequencer is busy
    bus.in_rs1 = 2'd1; bus.in_imm = 8'h01;
    nacc = 0; ndone = 0; bedge = -1;
    for (int c = 1; c <= 12; c++) begin
      will_acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (will_acc) begin nacc++; bedge = c; bus.in_valid = 1'b0; end
      if (done === 1'b1) ndone++;
    end
    bus.in_valid = 1'b0;
    ntests++; if (nacc !== 1) begin nfail++; $display("FAIL b2b_accepts: got %0d want 1", nacc); end
    ntests++; if (bedge !== 4) begin nfail++; $display("FAIL b2b_accept_cycle: got %0d want 4", bedge); end
    ntests++; if (ndone !== 2) begin nfail++; $display("FAIL b2b_done_count: got %0d want 2", ndone); end
    rd_reg(2'd1, d);
    ntests++; if (d !== 8'h06) begin nfail++; $display("FAIL b2b_r1: got %h want 06", d); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0;
    bus.in_rs2 = '0; bus.in_imm_en = 1'b0; bus.in_imm = '0;
    test_reset();
    test_add_imm();
    test_add_overflow();
    test_add_carry_zero();
    test_and_reg();
    test_not();
    test_illegal();
    test_reset_mid_exec();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
Multi-cycle execute sequencer that sits around the combinational alu.
- Upstream: accepts one decoded instruction at a time over a valid/ready handshake.
- Reads operands from an internal register file and drives the alu opcode/a/b inputs.
- Downstream: captures alu res and the four flags, then writes the result back into the register file and a flags register.
- The alu is instantiated by the parent. This block connects to it only through its alu_* ports.

Parameters:
DATA_W, 8, datapath/register width (must equal alu width)
NUM_REGS, 4, register file depth
RSEL_W, 2, register index width, clog2(NUM_REGS)
OP_W, 3, alu opcode width

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  instruction fields valid
in_ready  output  1  sequencer can accept an instruction
in_op  input  OP_W  alu opcode: 000 ADD, 001 AND, 010 NOT; 011-111 illegal
in_rd  input  RSEL_W  destination register
in_rs1  input  RSEL_W  source for alu a
in_rs2  input  RSEL_W  source for alu b (ignored when in_imm_en=1)
in_imm_en  input  1  select in_imm as alu b
in_imm  input  DATA_W  immediate operand
alu_opcode  output  OP_W  to alu opcode
alu_a  output  DATA_W  to alu a
alu_b  output  DATA_W  to alu b
alu_res  input  DATA_W  from alu res
alu_carry  input  1  from alu carry_flag
alu_zero  input  1  from alu zero_flag
alu_ovf  input  1  from alu overflow_flag
alu_sign  input  1  from alu sign_flag
flags  output  4  registered {carry, zero, overflow, sign}
done  output  1  one-cycle pulse: instruction retired
illegal_op  output  1  one-cycle pulse with done for an illegal opcode
dbg_sel  input  RSEL_W  debug read select
dbg_data  output  DATA_W  combinational read of regs[dbg_sel]

Behaviour:
- Reset (rst=1 at a clk edge), applied from any state including mid-instruction:
  - State goes to IDLE and any in-flight instruction is discarded without writeback.
  - All registers, flags, alu_opcode/alu_a/alu_b are cleared to 0.
  - done=0, illegal_op=0.
  - in_ready=1 in the first cycle after reset.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch op, rd, rs1, rs2, imm_en and imm; go to READ.
  - in_valid=0 holds IDLE.
- READ:
  - in_ready=0.
  - Register alu_opcode=op, alu_a=regs[rs1], alu_b = imm_en ? imm : regs[rs2]; go to EXEC.
- EXEC:
  - alu settles combinationally.
  - Capture alu_res and the four alu flags into internal result registers; go to WB.
- WB, legal op:
  - regs[rd] <= result; flags <= captured flags.
  - done=1 for this cycle; go to IDLE.
- WB, illegal op:
  - No register or flag write.
  - done=1 and illegal_op=1; go to IDLE.
- Latency and throughput:
  - Handshake at cycle N gives done at cycle N+3, with the write visible on dbg_data from cycle N+4.
  - Throughput is one instruction per 4 cycles; no pipelining.
- alu_opcode/alu_a/alu_b hold their last values outside READ.
- Operand hazards are impossible: writeback completes before the next accept.
- rd==rs1 or rd==rs2 is legal: the source value is the pre-write value.
- Instruction fields presented while in_ready=0 are ignored; upstream must hold them until accepted.
- Flags are never modified by reset release, dbg reads or illegal ops.
- Arithmetic: result is exactly DATA_W bits from the alu; no width extension. The block trusts the alu flag semantics.

Decomposition:
- Shared package (cpu_pkg):
  - Opcode constants OP_ADD=3'b000, OP_AND=3'b001, OP_NOT=3'b010.
  - Flag bit indices FLAG_C=3, FLAG_Z=2, FLAG_V=1, FLAG_S=0.
  - FSM state encoding.
- Sub-module: regfile (NUM_REGS x DATA_W).
  - Two async read ports plus the dbg port.
  - One sync write port with synchronous active-high reset.
  - Sequencer FSM stays in alu_exec_seq.

Test Plan (bench instantiates alu_exec_seq + alu):
- Reset, then IMM ADD rd=1, rs1=0, imm=0x0F:
  - done pulses 3 cycles after accept.
  - regs[1]=0x0F, flags=0000.
- ADD rd=2, rs1=1, imm=0x01 with regs[1]=0x7F:
  - regs[2]=0x80, overflow=1, sign=1, carry=0, zero=0.
- ADD rd=3, rs1=2, imm=0x01 with regs[2]=0xFF:
  - regs[3]=0x00, zero=1, carry=1.
- AND rd=1, rs1=1, rs2=2 with regs 0xCC, 0xAA:
  - regs[1]=0x88.
- NOT rd=0, rs1=3 with regs[3]=0x0F:
  - regs[0]=0xF0.
- Illegal op 3'b111 rd=1:
  - done=1 and illegal_op=1 in the same cycle.
  - regs[1] and flags unchanged.
- Reset asserted during EXEC, and in_valid held high while busy:
  - No writeback occurs and state returns to IDLE.
  - Held instruction accepted only when in_ready=1, exactly once.
